// File: rtl/uart_receiver_if.sv
// Serial-receive bundle: line input plus received byte, strobes and busy flag.
// master = the receiver itself, slave = whoever drives rx and consumes bytes.
`timescale 1ns/1ps
interface uart_receiver_if;
   logic       rx;
   logic [7:0] data_out;
   logic       data_valid;
   logic       frame_error;
   logic       busy;

   modport master (
      input  rx,
      output data_out,
      output data_valid,
      output frame_error,
      output busy
   );

   modport slave (
      output rx,
      input  data_out,
      input  data_valid,
      input  frame_error,
      input  busy
   );
endinterface

// File: rtl/uart_receiver.sv
// Oversampling 8N1 UART receiver with centre sampling and break handling.
// Optional even parity (8E1) when UART_RX_PARITY_EN is defined.
`timescale 1ns/1ps
module uart_receiver #(
   parameter int CLK_FREQ  = 10_000_000,
   parameter int BAUD_RATE = 115_200
) (
   input  logic              clk,
   input  logic              reset,
   uart_receiver_if.master   bus
);
   // state    | meaning
   // S_IDLE   | line idle, waiting for a low rx_s
   // S_START  | half-bit wait, then confirm start bit is still low
   // S_DATA   | sample 8 data bits at bit centres, LSB first
   // S_PARITY | sample even-parity bit (parity build only)
   // S_STOP   | sample stop bit, emit data_valid or frame_error
   // S_BREAK  | line held low after a bad stop bit, wait for high

   localparam int CLKS_PER_BIT = CLK_FREQ / BAUD_RATE;
   localparam int CNT_W        = $clog2(CLKS_PER_BIT);
   localparam logic [CNT_W-1:0] HALF_M1 = CNT_W'(CLKS_PER_BIT / 2 - 1);
   localparam logic [CNT_W-1:0] FULL_M1 = CNT_W'(CLKS_PER_BIT - 1);

   typedef enum logic [2:0] {
      S_IDLE,
      S_START,
      S_DATA,
`ifdef UART_RX_PARITY_EN
      S_PARITY,
`endif
      S_STOP,
      S_BREAK
   } state_t;

   state_t           state_q, state_d;
   logic [1:0]       sync_q, sync_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic [2:0]       bit_q, bit_d;
   logic [7:0]       shreg_q, shreg_d;
   logic [7:0]       data_q, data_d;
   logic             valid_q, valid_d;
   logic             ferr_q, ferr_d;
   logic             rx_s;
   logic             par_err;

`ifdef UART_RX_PARITY_EN
   logic par_q, par_d;
   assign par_err = ^{shreg_q, par_q};
`else
   assign par_err = 1'b0;
`endif

   assign sync_d = {sync_q[0], bus.rx};
   assign rx_s   = sync_q[1];

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q <= S_IDLE;
         sync_q  <= 2'b11;
         cnt_q   <= '0;
         bit_q   <= '0;
         shreg_q <= '0;
         data_q  <= '0;
         valid_q <= 1'b0;
         ferr_q  <= 1'b0;
`ifdef UART_RX_PARITY_EN
         par_q   <= 1'b0;
`endif
      end else begin
         state_q <= state_d;
         sync_q  <= sync_d;
         cnt_q   <= cnt_d;
         bit_q   <= bit_d;
         shreg_q <= shreg_d;
         data_q  <= data_d;
         valid_q <= valid_d;
         ferr_q  <= ferr_d;
`ifdef UART_RX_PARITY_EN
         par_q   <= par_d;
`endif
      end
   end

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q + 1'b1;
      bit_d   = bit_q;
      shreg_d = shreg_q;
      data_d  = data_q;
      valid_d = 1'b0;
      ferr_d  = 1'b0;
`ifdef UART_RX_PARITY_EN
      par_d   = par_q;
`endif
      case (state_q)
         S_IDLE: begin
            cnt_d = '0;
            if (!rx_s) state_d = S_START;
         end
         S_START: begin
            if (cnt_q == HALF_M1) begin
               cnt_d   = '0;
               bit_d   = '0;
               state_d = rx_s ? S_IDLE : S_DATA;
            end
         end
         S_DATA: begin
            if (cnt_q == FULL_M1) begin
               cnt_d   = '0;
               shreg_d = {rx_s, shreg_q[7:1]};
               bit_d   = bit_q + 3'd1;
               if (bit_q == 3'd7) begin
`ifdef UART_RX_PARITY_EN
                  state_d = S_PARITY;
`else
                  state_d = S_STOP;
`endif
               end
            end
         end
`ifdef UART_RX_PARITY_EN
         S_PARITY: begin
            if (cnt_q == FULL_M1) begin
               cnt_d   = '0;
               par_d   = rx_s;
               state_d = S_STOP;
            end
         end
`endif
         S_STOP: begin
            if (cnt_q == FULL_M1) begin
               cnt_d = '0;
               // Leaving mid-stop-bit lets a zero-gap next start edge be caught.
               if (rx_s && !par_err) begin
                  data_d  = shreg_q;
                  valid_d = 1'b1;
                  state_d = S_IDLE;
               end else begin
                  ferr_d  = 1'b1;
                  state_d = rx_s ? S_IDLE : S_BREAK;
               end
            end
         end
         S_BREAK: begin
            cnt_d = '0;
            if (rx_s) state_d = S_IDLE;
         end
         default: begin
            cnt_d   = '0;
            state_d = S_IDLE;
         end
      endcase
   end

   assign bus.data_out    = data_q;
   assign bus.data_valid  = valid_q;
   assign bus.frame_error = ferr_q;
   assign bus.busy        = (state_q != S_IDLE);
endmodule

// File: tb/tb_uart_receiver.sv
// Scoreboard bench for uart_receiver: stimulus pushes expected pulses, a monitor pops and compares.
`timescale 1ns/1ps
module tb_uart_receiver;
   localparam int CLK_FREQ = 1_000_000;
   localparam int BAUD     = 100_000;
   localparam int CPB      = 10;
`ifdef UART_RX_PARITY_EN
   localparam bit PAR_EN   = 1'b1;
`else
   localparam bit PAR_EN   = 1'b0;
`endif
   localparam int FRAME_CLKS = PAR_EN ? 110 : 100;
   localparam int LAT_MIN    = PAR_EN ? 106 : 96;
   localparam int LAT_MAX    = PAR_EN ? 109 : 99;

   logic clk = 1'b0;
   logic reset = 1'b1;
   always #5 clk = ~clk;

   uart_receiver_if bus();

   uart_receiver #(.CLK_FREQ(CLK_FREQ), .BAUD_RATE(BAUD)) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   typedef struct packed {
      logic       is_err;
      logic [7:0] data;
   } exp_t;

   exp_t       sb_q[$];
   int         vt_q[$];
   int         total = 0;
   int         bad = 0;
   int         cyc = 0;
   int         t_start = 0;
   logic [7:0] last_good = 8'h00;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   always @(negedge clk) begin
      if (!reset && (bus.data_valid || bus.frame_error)) begin
         exp_t e;
         check("pulse_exclusive", 32'(bus.data_valid & bus.frame_error), 32'd0);
         if (sb_q.size() == 0) begin
            total++;
            bad++;
            $display("FAIL unexpected_pulse: valid=%0b error=%0b data_out=%02h, no pulse expected (cycle %0d)",
                     bus.data_valid, bus.frame_error, bus.data_out, cyc);
         end else begin
            e = sb_q.pop_front();
            check("pulse_kind_is_error", 32'(bus.frame_error), 32'(e.is_err));
            check("data_out", 32'(bus.data_out), 32'(e.data));
         end
         if (bus.data_valid) vt_q.push_back(cyc);
      end
   end

   task automatic send_bit(input logic b);
      @(posedge clk);
      #1 bus.rx = b;
      repeat (CPB - 1) @(posedge clk);
   endtask

   task automatic send_frame(input logic [7:0] d, input logic stop_bit, input logic bad_par);
      exp_t e;
      logic good;
      good = stop_bit && !(PAR_EN && bad_par);
      if (good) begin
         e = '{is_err: 1'b0, data: d};
         last_good = d;
      end else begin
         e = '{is_err: 1'b1, data: last_good};
      end
      sb_q.push_back(e);
      @(posedge clk);
      #1 bus.rx = 1'b0;
      t_start = cyc;
      repeat (CPB - 1) @(posedge clk);
      for (int i = 0; i < 8; i++) send_bit(d[i]);
      if (PAR_EN) send_bit((^d) ^ bad_par);
      send_bit(stop_bit);
   endtask

   task automatic drain(input string name);
      for (int i = 0; i < 400 && sb_q.size() != 0; i++) @(posedge clk);
      check(name, 32'(sb_q.size()), 32'd0);
      repeat (CPB) @(posedge clk);
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $display("test done: total=%0d bad=%0d", total, bad + 1);
      $fatal(1, "watchdog");
   end

   initial begin
      int lat;
      int diff;
      int busy_cnt;
      bus.rx = 1'b1;
      reset  = 1'b1;
      repeat (5) @(posedge clk);
      @(negedge clk);
      check("reset_busy", 32'(bus.busy), 32'd0);
      check("reset_data_out", 32'(bus.data_out), 32'h00);
      #1 reset = 1'b0;

      // idle line
      repeat (200) @(posedge clk);
      @(negedge clk);
      check("idle_valid", 32'(bus.data_valid), 32'd0);
      check("idle_error", 32'(bus.frame_error), 32'd0);
      check("idle_busy", 32'(bus.busy), 32'd0);
      check("idle_data_out", 32'(bus.data_out), 32'h00);

      // single byte and latency
      vt_q.delete();
      send_frame(8'hA5, 1'b1, 1'b0);
      drain("drain_a5");
      lat = (vt_q.size() == 1) ? vt_q[0] - t_start : -1;
      check("a5_single_pulse", 32'(vt_q.size()), 32'd1);
      check("a5_latency_window", 32'(lat >= LAT_MIN && lat <= LAT_MAX), 32'd1);

      // zero-gap back-to-back frames
      vt_q.delete();
      send_frame(8'h3C, 1'b1, 1'b0);
      send_frame(8'hFF, 1'b1, 1'b0);
      drain("drain_b2b");
      check("b2b_pulse_count", 32'(vt_q.size()), 32'd2);
      diff = (vt_q.size() == 2) ? vt_q[1] - vt_q[0] : -1;
      check("b2b_spacing", 32'(diff), 32'(FRAME_CLKS));

      // 3-clock glitch
      @(posedge clk);
      #1 bus.rx = 1'b0;
      repeat (3) @(posedge clk);
      #1 bus.rx = 1'b1;
      busy_cnt = 0;
      for (int i = 0; i < 30; i++) begin
         @(negedge clk);
         if (bus.busy) busy_cnt++;
      end
      check("glitch_busy_seen", 32'(busy_cnt > 0), 32'd1);
      check("glitch_busy_max8", 32'(busy_cnt <= 8), 32'd1);
      check("glitch_busy_end", 32'(bus.busy), 32'd0);

      // bad stop bit followed by a held-low line, then recovery
      send_frame(8'h55, 1'b0, 1'b0);
      repeat (300) @(posedge clk);
      #1 bus.rx = 1'b1;
      repeat (20) @(posedge clk);
      check("break_one_error", 32'(sb_q.size()), 32'd0);
      send_frame(8'h12, 1'b1, 1'b0);
      drain("drain_12");

      // reset in the middle of bit 4; bits 4..7 and parity of 8'hF1 are all high
      @(posedge clk);
      #1 bus.rx = 1'b0;
      repeat (CPB - 1) @(posedge clk);
      send_bit(1'b1);
      send_bit(1'b0);
      send_bit(1'b0);
      send_bit(1'b0);
      @(posedge clk);
      #1 bus.rx = 1'b1;
      repeat (4) @(posedge clk);
      #1 reset = 1'b1;
      @(posedge clk);
      #1 reset = 1'b0;
      @(negedge clk);
      check("midreset_busy", 32'(bus.busy), 32'd0);
      check("midreset_data_out", 32'(bus.data_out), 32'h00);
      last_good = 8'h00;
      repeat (80) @(posedge clk);
      send_frame(8'h81, 1'b1, 1'b0);
      drain("drain_81");

      if (PAR_EN) begin
         send_frame(8'h07, 1'b1, 1'b1);
         drain("drain_par_bad");
         send_frame(8'h07, 1'b1, 1'b0);
         drain("drain_par_good");
      end

      repeat (50) @(posedge clk);
      check("final_queue_empty", 32'(sb_q.size()), 32'd0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
